// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side arbiter.
//   HDR_MARK         : high bit set on every channel-ID header byte
//   uart_arb_state_t : arbiter FSM state encoding
//   hdr_byte()       : builds the header byte for a requester index
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [7:0] HDR_MARK = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } uart_arb_state_t;

  // Up to 128 requesters, so the ID fits in the 7 bits below the marker.
  function automatic logic [7:0] hdr_byte(input logic [6:0] id);
    return HDR_MARK | {1'b0, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Returns the first set request bit found
// scanning upward from ptr, wrapping from N-1 back to 0.
// Ports:
//   req     [N]  : request vector
//   ptr     [GW] : highest-priority index (must be < N)
//   gnt_vld      : at least one request is set
//   gnt_idx [GW] : winning index (0 when gnt_vld is low)
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          gnt_vld,
  output logic [GW-1:0] gnt_idx
);

  // Doubling the vector turns the wrap-around scan into a linear one:
  // bits ptr..ptr+N-1 of {req,req} are the requests in priority order.
  logic [2*N-1:0] w_dbl;
  assign w_dbl = {req, req};

  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Scan downward so the lowest offset from ptr is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (w_dbl[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'((j >= N) ? (j - N) : j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte transmitter among N_REQ byte-stream requesters at
// packet granularity. Round-robin grant, held until the tlast byte
// transfers. With HEADER=1 a channel-ID byte (HDR_MARK|id) precedes each
// packet so the far end can demultiplex.
// Ports:
//   clk, rst               : clock, async active-high reset
//   req_tvalid/tdata/tlast : per-requester byte streams (tdata [8*i+:8])
//   req_tready             : per-requester ready (only granted one may rise)
//   str_tvalid/tdata       : byte stream to UART transmitter
//   str_tready             : UART transmitter ready
//   busy                   : grant held (state != IDLE)
//   grant_id               : current / last granted requester
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int HEADER = 1,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_tvalid,
  input  logic [N_REQ*8-1:0] req_tdata,
  input  logic [N_REQ-1:0]   req_tlast,
  output logic [N_REQ-1:0]   req_tready,
  output logic               str_tvalid,
  output logic [7:0]         str_tdata,
  input  logic               str_tready,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  uart_arb_state_t r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;

  logic            w_gnt_vld;
  logic [GW-1:0]   w_gnt_idx;
  logic            w_g_valid;
  logic            w_g_last;
  logic [7:0]      w_g_data;
  logic [GW-1:0]   w_next_ptr;

  rr_arbiter #(.N(N_REQ), .GW(GW)) u_rr (
    .req     (req_tvalid),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  // Granted requester's stream; everyone else is ignored.
  assign w_g_valid = req_tvalid[r_grant_id];
  assign w_g_last  = req_tlast[r_grant_id];
  assign w_g_data  = req_tdata[8*r_grant_id +: 8];

  assign w_next_ptr = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_grant_id <= w_gnt_idx;
            r_state    <= (HEADER != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (str_tready) r_state <= DATA;
        end
        DATA: begin
          // Grant is released only when the tlast byte actually transfers.
          if (w_g_valid && str_tready && w_g_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output mux: header is built from registered grant_id so it is stable
  // under backpressure; DATA is a straight pass-through of the granted lane.
  always_comb begin
    str_tvalid = 1'b0;
    str_tdata  = 8'h00;
    req_tready = '0;
    case (r_state)
      HDR: begin
        str_tvalid = 1'b1;
        str_tdata  = hdr_byte(7'(r_grant_id));
      end
      DATA: begin
        str_tvalid             = w_g_valid;
        str_tdata              = w_g_data;
        req_tready[r_grant_id] = str_tready;
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant_id;

endmodule
